// File: rtl/brush_stamp_writer.sv
// Stamps a square brush of material into VRAM around the mouse, one granted write per cycle.
// Define BRUSH_CIRCLE_EN to restrict the footprint to the disc dx^2+dy^2 <= r^2.
module brush_stamp_writer #(
  parameter int COLUMNS    = 640,
  parameter int ROWS       = 400,
  parameter int ADDR_WIDTH = $clog2(COLUMNS*ROWS),
  parameter int DATA_WIDTH = 2,
  parameter int MAX_RADIUS = 7
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           draw_en_i,
  input  logic [$clog2(COLUMNS)-1:0]     mouse_x_position_i,
  input  logic [$clog2(ROWS)-1:0]        mouse_y_position_i,
  input  logic [DATA_WIDTH-1:0]          pixel_type_i,
  input  logic [$clog2(MAX_RADIUS+1)-1:0] radius_i,
  input  logic                           wr_grant_i,
  output logic [ADDR_WIDTH-1:0]          wr_address_o,
  output logic [DATA_WIDTH-1:0]          wr_data_o,
  output logic                           wr_en_o,
  output logic                           busy_o,
  output logic                           done_o
);

  localparam int XW = $clog2(COLUMNS);
  localparam int YW = $clog2(ROWS);
  localparam int RW = $clog2(MAX_RADIUS+1);
  localparam logic signed [RW:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, STAMP, DONE} state_t;
  state_t state;

  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic [DATA_WIDTH-1:0] type_q;
  logic [RW-1:0]         r_q;
  logic signed [RW:0]    dx_q, dy_q;
  logic                  in_bounds_q, mask_q;

  logic [XW-1:0]         src_x;
  logic [YW-1:0]         src_y;
  logic [RW-1:0]         src_r, r_clamp;
  logic signed [RW:0]    r_pos, nxt_dx, nxt_dy;
  logic                  last_cell;
  logic signed [XW:0]    tx;
  logic signed [YW:0]    ty;
  logic                  nxt_in_bounds, nxt_mask;
  logic [ADDR_WIDTH-1:0] nxt_addr;

  assign r_clamp = (radius_i > RW'(MAX_RADIUS)) ? RW'(MAX_RADIUS) : radius_i;

  // Everything registered describes the cell presented next cycle, so compute it one step ahead.
  always_comb begin
    src_x = x_q;
    src_y = y_q;
    src_r = r_q;
    if (state == IDLE) begin
      src_x = mouse_x_position_i;
      src_y = mouse_y_position_i;
      src_r = r_clamp;
    end
    r_pos     = $signed({1'b0, src_r});
    last_cell = (dx_q == r_pos) && (dy_q == r_pos);
    nxt_dx    = -r_pos;
    nxt_dy    = -r_pos;
    if (state == STAMP) begin
      if (dx_q != r_pos) begin
        nxt_dx = dx_q + ONE;
        nxt_dy = dy_q;
      end else begin
        nxt_dx = -r_pos;
        nxt_dy = dy_q + ONE;
      end
    end
    tx = $signed({1'b0, src_x}) + $signed({{(XW-RW){nxt_dx[RW]}}, nxt_dx});
    ty = $signed({1'b0, src_y}) + $signed({{(YW-RW){nxt_dy[RW]}}, nxt_dy});
    nxt_in_bounds = !tx[XW] && ({1'b0, tx[XW-1:0]} < (XW+1)'(COLUMNS)) &&
                    !ty[YW] && ({1'b0, ty[YW-1:0]} < (YW+1)'(ROWS));
    nxt_addr = ADDR_WIDTH'(ty[YW-1:0]) * ADDR_WIDTH'(COLUMNS) + ADDR_WIDTH'(tx[XW-1:0]);
  end

`ifdef BRUSH_CIRCLE_EN
  localparam int SW = 2*RW+1;
  logic [RW-1:0] adx, ady;
  logic [SW-1:0] dist_sq, r_sq;

  always_comb begin
    adx      = nxt_dx[RW] ? RW'(-nxt_dx) : nxt_dx[RW-1:0];
    ady      = nxt_dy[RW] ? RW'(-nxt_dy) : nxt_dy[RW-1:0];
    dist_sq  = SW'(adx) * SW'(adx) + SW'(ady) * SW'(ady);
    r_sq     = SW'(src_r) * SW'(src_r);
    nxt_mask = (dist_sq <= r_sq);
  end
`else
  assign nxt_mask = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      type_q       <= '0;
      r_q          <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      in_bounds_q  <= 1'b0;
      mask_q       <= 1'b0;
      wr_address_o <= '0;
      wr_data_o    <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (draw_en_i) begin
            x_q          <= mouse_x_position_i;
            y_q          <= mouse_y_position_i;
            type_q       <= pixel_type_i;
            r_q          <= r_clamp;
            dx_q         <= nxt_dx;
            dy_q         <= nxt_dy;
            in_bounds_q  <= nxt_in_bounds;
            mask_q       <= nxt_mask;
            wr_address_o <= nxt_addr;
            wr_data_o    <= pixel_type_i;
            busy_o       <= 1'b1;
            state        <= STAMP;
          end
        end
        STAMP: begin
          if (wr_grant_i) begin
            if (last_cell) begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              dx_q         <= nxt_dx;
              dy_q         <= nxt_dy;
              in_bounds_q  <= nxt_in_bounds;
              mask_q       <= nxt_mask;
              wr_address_o <= nxt_addr;
              wr_data_o    <= type_q;
            end
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_en_o = (state == STAMP) && wr_grant_i && in_bounds_q && mask_q;

endmodule

// File: tb/tb_brush_stamp_writer.sv
// Directed bench for brush_stamp_writer: clipping at both corners, stalls, reset mid-stamp.
module tb_brush_stamp_writer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        draw_en_i;
  logic [9:0]  mouse_x_position_i;
  logic [8:0]  mouse_y_position_i;
  logic [1:0]  pixel_type_i;
  logic [2:0]  radius_i;
  logic        wr_grant_i;
  logic [17:0] wr_address_o;
  logic [1:0]  wr_data_o;
  logic        wr_en_o;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;
  int wr_q[$];
  int exp_q[$];
  int granted_cycles, busy_cycles, stall_writes, bad_data, busy_at_done;
  bit done_seen;

  brush_stamp_writer dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .draw_en_i          (draw_en_i),
    .mouse_x_position_i (mouse_x_position_i),
    .mouse_y_position_i (mouse_y_position_i),
    .pixel_type_i       (pixel_type_i),
    .radius_i           (radius_i),
    .wr_grant_i         (wr_grant_i),
    .wr_address_o       (wr_address_o),
    .wr_data_o          (wr_data_o),
    .wr_en_o            (wr_en_o),
    .busy_o             (busy_o),
    .done_o             (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int x, input int y, input logic [1:0] ptype, input int r);
    @(negedge clk_i);
    mouse_x_position_i = 10'(x);
    mouse_y_position_i = 9'(y);
    pixel_type_i       = ptype;
    radius_i           = 3'(r);
    draw_en_i          = 1'b1;
    wr_grant_i         = 1'b1;
  endtask

  // Observes one stamp mid-cycle; scrambles inputs once busy to prove they are latched.
  task automatic collectStamp(input int budget, input bit toggle, input logic [1:0] ptype);
    wr_q.delete();
    granted_cycles = 0;
    busy_cycles    = 0;
    stall_writes   = 0;
    bad_data       = 0;
    busy_at_done   = 0;
    done_seen      = 0;
    for (int c = 0; c < budget && !done_seen; c++) begin
      @(negedge clk_i);
      wr_grant_i = toggle ? (c % 2 == 0) : 1'b1;
      #1;
      if (busy_o) begin
        busy_cycles++;
        if (wr_grant_i) granted_cycles++;
        draw_en_i          = 1'b0;
        mouse_x_position_i = 10'd5;
        mouse_y_position_i = 9'd5;
        pixel_type_i       = ~ptype;
        radius_i           = 3'd0;
      end
      if (wr_en_o) begin
        if (!wr_grant_i) stall_writes++;
        if (wr_data_o !== ptype) bad_data++;
        wr_q.push_back(int'(wr_address_o));
      end
      if (done_o) begin
        done_seen    = 1;
        busy_at_done = int'(busy_o);
      end
    end
    wr_grant_i = 1'b1;
    checkOutput("done_seen", 32'(done_seen), 32'd1);
  endtask

  task automatic compareWrites(input string tag);
    checkOutput({tag, "_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      checkOutput($sformatf("%s_addr%0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int hits;
    reset_i = 1'b1;
    draw_en_i = 1'b0;
    mouse_x_position_i = '0;
    mouse_y_position_i = '0;
    pixel_type_i = '0;
    radius_i = '0;
    wr_grant_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_addr", 32'(wr_address_o), 32'd0);
    checkOutput("rst_data", 32'(wr_data_o), 32'd0);
    checkOutput("rst_en", 32'(wr_en_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    reset_i = 1'b0;

    $display("[TB] r=0 single cell at (10,20)");
    applyStimulus(10, 20, 2'b01, 0);
    collectStamp(20, 1'b0, 2'b01);
    exp_q = '{12810};
    compareWrites("r0");
    checkOutput("r0_busy_cycles", 32'(busy_cycles), 32'd1);
    checkOutput("r0_busy_at_done", 32'(busy_at_done), 32'd0);
    checkOutput("r0_bad_data", 32'(bad_data), 32'd0);

    $display("[TB] r=1 at top-left corner");
    applyStimulus(0, 0, 2'b10, 1);
    collectStamp(40, 1'b0, 2'b10);
    exp_q = '{0, 1, 640, 641};
    compareWrites("r1_tl");
    checkOutput("r1_tl_cycles", 32'(granted_cycles), 32'd9);
    checkOutput("r1_tl_bad_data", 32'(bad_data), 32'd0);

    $display("[TB] r=1 at bottom-right corner");
    applyStimulus(639, 399, 2'b11, 1);
    collectStamp(40, 1'b0, 2'b11);
    exp_q = '{255358, 255359, 255998, 255999};
    compareWrites("r1_br");
    checkOutput("r1_br_cycles", 32'(granted_cycles), 32'd9);
    checkOutput("r1_br_busy_at_done", 32'(busy_at_done), 32'd0);

    $display("[TB] r=2 at (100,100) with toggling grant");
    applyStimulus(100, 100, 2'b01, 2);
    collectStamp(120, 1'b1, 2'b01);
    exp_q.delete();
    for (int dy = -2; dy <= 2; dy++)
      for (int dx = -2; dx <= 2; dx++)
        exp_q.push_back((100 + dy) * 640 + 100 + dx);
    compareWrites("r2_stall");
    checkOutput("r2_stall_cycles", 32'(granted_cycles), 32'd25);
    checkOutput("r2_stall_writes", 32'(stall_writes), 32'd0);
    checkOutput("r2_bad_data", 32'(bad_data), 32'd0);

    $display("[TB] reset on 5th STAMP cycle of r=3 stamp");
    applyStimulus(200, 200, 2'b10, 3);
    hits = 0;
    for (int c = 0; c < 20 && hits < 5; c++) begin
      @(negedge clk_i);
      #1;
      if (busy_o) begin
        hits++;
        draw_en_i = 1'b0;
      end
    end
    checkOutput("rst_mid_reached", 32'(hits), 32'd5);
    reset_i = 1'b1;
    @(negedge clk_i);
    #1;
    checkOutput("rst_mid_addr", 32'(wr_address_o), 32'd0);
    checkOutput("rst_mid_data", 32'(wr_data_o), 32'd0);
    checkOutput("rst_mid_en", 32'(wr_en_o), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy_o), 32'd0);
    reset_i = 1'b0;
    hits = 0;
    repeat (4) begin
      @(negedge clk_i);
      #1;
      if (wr_en_o || busy_o) hits++;
    end
    checkOutput("rst_mid_quiet", 32'(hits), 32'd0);
    applyStimulus(10, 20, 2'b10, 0);
    collectStamp(20, 1'b0, 2'b10);
    exp_q = '{12810};
    compareWrites("restart");
    checkOutput("restart_bad_data", 32'(bad_data), 32'd0);

`ifdef BRUSH_CIRCLE_EN
    $display("[TB] circular r=2 at (50,50)");
    applyStimulus(50, 50, 2'b01, 2);
    collectStamp(60, 1'b0, 2'b01);
    checkOutput("circ_cycles", 32'(granted_cycles), 32'd25);
    checkOutput("circ_writes", 32'(wr_q.size()), 32'd13);
    hits = 0;
    foreach (wr_q[i]) if (wr_q[i] == 30768) hits++;
    checkOutput("circ_corner", 32'(hits), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/brush_stamp_writer.md
# brush_stamp_writer

Paints a square (or, optionally, circular) brush of sand-game material into VRAM around the current mouse position. It sits between the mouse position tracker / pixel-type selector and the VRAM write-port mux. It walks every cell of the brush footprint, clips cells that fall outside the playfield, and presents one VRAM write per granted cycle. When the port is not granted it stalls, so it can share the port with the game state controller.

## Interface
Parameters:
- COLUMNS, 640, playfield width in cells
- ROWS, 400, playfield height in cells
- ADDR_WIDTH, $clog2(COLUMNS*ROWS), VRAM address width
- DATA_WIDTH, 2, material code width
- MAX_RADIUS, 7, largest brush radius; radius_i is clamped to this value

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  system clock
- reset_i  in  1  synchronous active-high reset
- draw_en_i  in  1  level request to stamp (left mouse button)
- mouse_x_position_i  in  $clog2(COLUMNS)  brush centre column
- mouse_y_position_i  in  $clog2(ROWS)  brush centre row
- pixel_type_i  in  DATA_WIDTH  material to write
- radius_i  in  $clog2(MAX_RADIUS+1)  brush radius r
- wr_grant_i  in  1  VRAM write port owned by this block this cycle
- wr_address_o  out  ADDR_WIDTH  VRAM write address
- wr_data_o  out  DATA_WIDTH  VRAM write data
- wr_en_o  out  1  VRAM write strobe
- busy_o  out  1  stamp in progress; the top-level mux uses it as select
- done_o  out  1  one-cycle pulse when a stamp completes

## Operation
- FSM has three states: IDLE → STAMP → DONE → IDLE.
- In IDLE with draw_en_i=1, the block latches x, y, pixel_type_i and min(radius_i, MAX_RADIUS), loads dy=dx=−r, and moves to STAMP.
- In STAMP, dx is the inner loop and dy the outer loop, each running −r..+r. Counters advance only on cycles where wr_grant_i=1.
- Target cell is tx=x+dx, ty=y+dy, computed as signed values one bit wider than the coordinate.
- A cell is in bounds when 0≤tx<COLUMNS and 0≤ty<ROWS.
- For an out-of-bounds cell, wr_en_o=0 and the cycle is still consumed. Clipping never wraps to an adjacent row.
- wr_address_o = ty*COLUMNS + tx, truncated to ADDR_WIDTH. wr_data_o = the latched type.
- wr_en_o = (state==STAMP) & wr_grant_i & in_bounds & mask.
- After the granted cycle at (dx,dy)=(+r,+r), the FSM moves to DONE. done_o=1 for one cycle, then the FSM returns to IDLE.
- If draw_en_i is still high in IDLE, a new stamp starts with freshly latched inputs, giving a continuous brush while the button is held.
- Changes to mouse position, type, or radius during STAMP are ignored.
- Deasserting draw_en_i mid-stamp does not abort; the stamp completes.
- r=0 produces a single-cell stamp.

## Timing
- Reset behaviour: state=IDLE, counters=0, wr_address_o=0, wr_data_o=0, wr_en_o=0, busy_o=0, done_o=0 on the edge where reset_i=1.
- Reset during STAMP: no write is issued in any cycle after the reset edge.
- wr_address_o, wr_data_o, busy_o, done_o and the in-bounds/mask flags are registered. wr_en_o is combinational only through wr_grant_i.
- Edge N samples draw_en_i=1 in IDLE. From cycle N+1, busy_o=1 and the first cell is presented.
- With grant held high, the stamp takes (2r+1)² cycles in STAMP plus 1 cycle in DONE.
- busy_o is low during DONE. The earliest restart is the cycle after DONE.
- A deasserted wr_grant_i freezes counters and outputs. wr_en_o=0 during the stall, and no cell is skipped or duplicated.

## Configuration
- BRUSH_CIRCLE_EN defined: mask = (dx²+dy² ≤ r²). Cells outside the disc suppress wr_en_o but still consume a granted cycle. Squares are computed at width 2·$clog2(MAX_RADIUS+1)+1.
- BRUSH_CIRCLE_EN undefined: mask=1, giving a full square footprint; no multiplier for the mask is built.

## Test plan
- r=0, (x,y)=(10,20), type 2'b01, grant=1: exactly one write, addr 12810, data 01. busy_o high 1 cycle, then done_o pulse.
- r=1 at (0,0), grant=1: 9 STAMP cycles, exactly 4 writes in order, to addr 0, 1, 640, 641. No write to a wrapped address such as 639 or 255999.
- r=1 at (639,399): 4 writes to 255358, 255359, 255998, 255999. done_o follows the 9th STAMP cycle.
- r=2 at (100,100) with grant toggled 1,0,1,0…: exactly 25 writes, each address once, in raster order, with no wr_en_o while grant=0.
- Reset asserted on the 5th STAMP cycle of an r=3 stamp: outputs are zero from the next edge; restarts cleanly when draw_en_i=1.
- BRUSH_CIRCLE_EN, r=2 at (50,50): 25 STAMP cycles, exactly 13 writes; corner cells such as (48,48) are not written.
